// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, width defaults and
// instruction field positions used by both the fetch queue and decode.
package fetch_pkg;

  localparam int AW_DEFAULT = 4;
  localparam int IW_DEFAULT = 32;

  // Opcode field position inside an instruction word; decode extracts it too.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_MSB-OPC_LSB:0] inst_opcode(input logic [IW_DEFAULT-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with a flush that overrides
// any push or pop in the same cycle.
module fetch_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      // NOTE: storage is cleared on reset so the head reads 0 out of reset;
      // this is cheap at this depth and keeps outputs free of X.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: issues program-memory reads, buffers the
// returned words with their PC, and hands them to decode over valid/ready.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int IW    = IW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          sys_rst,
  output logic          imem_rd_en,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  output logic          inst_valid,
  output logic [IW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic          fetch_busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [AW-1:0]    pc_q;
  logic [AW-1:0]    pc_issued_q;
  logic             inflight_q;
  logic             drop_q;
  logic             rd_en;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count;
  logic [AW+IW-1:0] head;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (halt) state_d = S_HALT;
      S_HALT:  if (!halt) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy counts the queued words plus the one still in flight, so a
  // returning response always has a free slot.
  assign rd_en = (state_q == S_RUN) && !halt && !redirect_valid &&
                 ((count + CW'(inflight_q)) < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      pc_issued_q <= '0;
      inflight_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q    <= state_d;
      inflight_q <= rd_en;
      drop_q     <= redirect_valid;
      if (rd_en) begin
        pc_issued_q <= pc_q;
      end
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (rd_en) begin
        pc_q <= pc_q + AW'(1);
      end
    end
  end

  // A response landing just after a redirect belongs to the old path.
  assign push = inflight_q && !drop_q;
  assign pop  = inst_valid && inst_ready;

  fetch_fifo #(
    .W     (AW + IW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({pc_issued_q, imem_rdata}),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign imem_rd_en           = rd_en;
  assign imem_addr            = pc_q;
  assign inst_valid           = (count != '0);
  assign {inst_pc, inst_data} = head;
  assign fetch_busy           = inflight_q || inst_valid;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed latency/halt/redirect/reset
// scenarios plus a randomized phase, all checked against an in-order stream model.
module tb_inst_fetch_queue;

  localparam int AW    = 4;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam logic [IW-1:0] BASE = 32'hA000_0000;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          inst_valid;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic          fetch_busy;

  always #5 clk = ~clk;

  inst_fetch_queue #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .sys_rst        (sys_rst),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_busy     (fetch_busy)
  );

  // Synchronous program memory: word k holds BASE + k.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= BASE + 32'(imem_addr);
  end

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [AW-1:0] gen_pc;
  int            n_checks    = 0;
  int            n_errors    = 0;
  int            pop_count   = 0;
  int            outstanding = 0;
  logic          occ_ok;
  logic          prev_stall  = 1'b0;
  logic [AW-1:0] prev_pc;
  logic [IW-1:0] prev_data;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Program-order model: decode must see consecutive PCs (mod 2^AW) with
  // matching words, restarting at the target after a redirect or at 0 after reset.
  task refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, data: BASE + 32'(gen_pc)});
      gen_pc = gen_pc + 1'b1;
    end
  endtask

  task restart(input logic [AW-1:0] pc);
    exp_q.delete();
    gen_pc = pc;
    refill();
  endtask

  // Monitor: samples mid-cycle and compares every accepted instruction.
  initial begin
    restart('0);
    forever begin
      @(negedge clk);
      if (!sys_rst) begin
        restart('0);
        outstanding = 0;
        prev_stall  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(inst_valid), 32'd1);
          check("hold_pc", 32'(inst_pc), 32'(prev_pc));
          check("hold_data", inst_data, prev_data);
        end
        if (inst_valid && inst_ready) begin
          mon_e = exp_q.pop_front();
          check("stream_pc", 32'(inst_pc), 32'(mon_e.pc));
          check("stream_data", inst_data, mon_e.data);
          pop_count++;
          refill();
        end
        // Reads issued but not yet consumed can never exceed the queue depth.
        outstanding = outstanding + int'(imem_rd_en);
        occ_ok      = (outstanding <= DEPTH);
        if (inst_valid && inst_ready) outstanding--;
        occ_ok = occ_ok && (outstanding >= 0);
        check("occupancy", 32'(occ_ok), 32'd1);
        if (redirect_valid) begin
          restart(redirect_pc);
          outstanding = 0;
        end
        prev_stall = inst_valid && !inst_ready && !redirect_valid;
        prev_pc    = inst_pc;
        prev_data  = inst_data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task cyc();
    @(posedge clk);
    #1;
  endtask

  int            rd_cnt;
  int            pops0;
  logic          last_rd;
  logic [AW-1:0] next_pc;

  initial begin
    sys_rst        = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    repeat (3) cyc();

    // Reset state, then sequential stream from release (cycle 0).
    @(negedge clk);
    check("rst_rd_en", 32'(imem_rd_en), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", 32'(inst_pc), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    cyc();
    sys_rst    = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    check("c0_rd_en", 32'(imem_rd_en), 32'd0);
    cyc();
    @(negedge clk);
    check("c1_rd_en", 32'(imem_rd_en), 32'd1);
    check("c1_addr", 32'(imem_addr), 32'd0);
    check("c1_valid", 32'(inst_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("c2_valid", 32'(inst_valid), 32'd0);
    check("c2_busy", 32'(fetch_busy), 32'd1);
    cyc();
    @(negedge clk);
    check("c3_valid", 32'(inst_valid), 32'd1);
    check("c3_pc", 32'(inst_pc), 32'd0);
    check("c3_data", inst_data, BASE);
    for (int i = 0; i < 20; i++) begin
      cyc();
      @(negedge clk);
      check("stream_no_gap", 32'(inst_valid), 32'd1);
    end

    // Halt with three entries queued and one read in flight.
    cyc(); inst_ready = 1'b0;
    cyc();
    cyc(); halt = 1'b1;
    pops0 = pop_count;
    @(negedge clk);
    check("halt_rd_en_entry", 32'(imem_rd_en), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      inst_ready = 1'b1;
      @(negedge clk);
      check("halt_rd_en", 32'(imem_rd_en), 32'd0);
    end
    cyc();
    check("halt_drained", 32'(pop_count - pops0), 32'd4);
    @(negedge clk);
    check("halt_valid_low", 32'(inst_valid), 32'd0);
    check("halt_busy_low", 32'(fetch_busy), 32'd0);
    cyc();
    halt    = 1'b0;
    next_pc = exp_q[0].pc;
    cyc();
    @(negedge clk);
    check("resume_rd_en", 32'(imem_rd_en), 32'd1);
    check("resume_addr", 32'(imem_addr), 32'(next_pc));
    repeat (6) cyc();

    // Backpressure: reads stop once four words are held or in flight.
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      inst_ready = 1'b0;
      @(negedge clk);
      rd_cnt  = rd_cnt + int'(imem_rd_en);
      last_rd = imem_rd_en;
    end
    check("bp_reads", 32'(rd_cnt), 32'd2);
    check("bp_rd_en_stopped", 32'(last_rd), 32'd0);
    check("bp_valid", 32'(inst_valid), 32'd1);
    check("bp_busy", 32'(fetch_busy), 32'd1);
    cyc();
    inst_ready = 1'b1;
    repeat (8) cyc();

    // Reset with a full queue, then redirect while pc 3 is accepted.
    inst_ready = 1'b0;
    repeat (6) cyc();
    sys_rst = 1'b0;
    cyc();
    sys_rst    = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    check("mrst_valid", 32'(inst_valid), 32'd0);
    check("mrst_busy", 32'(fetch_busy), 32'd0);
    cyc();
    @(negedge clk);
    check("mrst_c1_rd_en", 32'(imem_rd_en), 32'd1);
    check("mrst_c1_addr", 32'(imem_addr), 32'd0);
    cyc();
    cyc();
    @(negedge clk);
    check("mrst_c3_valid", 32'(inst_valid), 32'd1);
    check("mrst_c3_pc", 32'(inst_pc), 32'd0);
    cyc();
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 4'd9;
    @(negedge clk);
    check("redir_head_pc", 32'(inst_pc), 32'd3);
    check("redir_head_valid", 32'(inst_valid), 32'd1);
    check("redir_no_read", 32'(imem_rd_en), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_t1_valid", 32'(inst_valid), 32'd0);
    check("redir_t1_rd_en", 32'(imem_rd_en), 32'd1);
    check("redir_t1_addr", 32'(imem_addr), 32'd9);
    cyc();
    cyc();
    @(negedge clk);
    check("redir_t3_valid", 32'(inst_valid), 32'd1);
    check("redir_t3_pc", 32'(inst_pc), 32'd9);
    check("redir_t3_data", inst_data, BASE + 32'd9);

    // Randomized traffic: backpressure, redirects and halt bursts.
    for (int i = 0; i < 500; i++) begin
      cyc();
      inst_ready     = ($urandom_range(9) < 7);
      redirect_valid = ($urandom_range(31) == 0);
      redirect_pc    = AW'($urandom);
      halt           = halt ? ($urandom_range(3) != 0) : ($urandom_range(29) == 0);
    end
    cyc();
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    repeat (20) cyc();
    @(negedge clk);
    check("final_streaming", 32'(inst_valid), 32'd1);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch front-end for the 16-bit processor core; sits directly upstream of the decode/execute stage.
- Reads 32-bit instruction words from the synchronous program memory and buffers them, tagged with their PC, in a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Accepts jump redirects (queue flush) and a halt hold from the core.

Parameters:
- AW, 4, program memory address / PC width (16 words).
- IW, 32, instruction word width.
- DEPTH, 4, prefetch queue entries (power of 2, >= 2).

Ports:
- clk  input  1  system clock.
- sys_rst  input  1  reset; synchronous, active-low.
- imem_rd_en  output  1  program memory read strobe.
- imem_addr  output  AW  program memory read address.
- imem_rdata  input  IW  read data; valid in the cycle after imem_rd_en.
- inst_valid  output  1  queue head holds a valid instruction.
- inst_data  output  IW  head instruction word.
- inst_pc  output  AW  PC of the head instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- redirect_valid  input  1  jump taken; flush and refetch.
- redirect_pc  input  AW  jump target.
- halt  input  1  level; stop issuing new reads.
- fetch_busy  output  1  read in flight or queue non-empty.

Behaviour:
- Reset (sys_rst=0 at clk edge):
  - State S_IDLE; pc=0, count=0, inflight=0, all queue storage=0.
  - Outputs: imem_rd_en=0, imem_addr=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_busy=0.
  - A reset mid-operation discards all queued and in-flight data.
- FSM:
  - S_IDLE: always goes to S_RUN on the next edge. Lasts one cycle after reset release.
  - S_RUN:
    - Issue a read (imem_rd_en=1, imem_addr=pc, pc<=pc+1) when count+inflight < DEPTH. Count is taken before any same-cycle pop.
    - halt=1 -> go to S_HALT; no read is issued in that cycle.
  - S_HALT:
    - No reads issued. The queue keeps draining to decode; the in-flight response is still captured.
    - halt=0 -> go to S_RUN; issue resumes from the current pc.
- Latency:
  - rd_en in cycle t; rdata captured at the end of t+1; inst_valid in cycle t+2.
  - After reset release, the first rd_en (addr 0) is in cycle 1 and the first inst_valid in cycle 3.
  - Sustained throughput is one instruction per cycle with inst_ready held high.
- inflight: registered copy of imem_rd_en. When set, the response is pushed into the queue with tag pc_issued, unless it is squashed.
- Handshake:
  - Pop when inst_valid & inst_ready.
  - inst_data and inst_pc are stable while inst_valid=1 and inst_ready=0.
  - Push and pop in the same cycle leave count unchanged.
- Redirect:
  - redirect_valid=1 in cycle t: a pop handshake in t still completes.
  - At the end of t: queue flushed (count=0), in-flight response squashed via a drop flag, pc<=redirect_pc.
  - No read is issued in cycle t. inst_valid=0 in t+1.
  - In S_RUN the first read of redirect_pc is issued in t+1.
  - In S_HALT the pc is updated but no read is issued until halt falls.
  - Redirect takes priority over halt entry in the same cycle: both actions apply.
- PC arithmetic is modulo 2^AW; pc 2^AW-1 wraps to 0 with no flag.
- Queue full (count=DEPTH) never occurs with an untaken read response, because of the issue rule. Overflow is impossible, and the bench asserts it.
- fetch_busy = inflight | (count != 0).

Decomposition:
- Shared package (fetch_pkg):
  - FSM state encodings S_IDLE, S_RUN, S_HALT.
  - IW and default AW constants.
  - Opcode field position macros, reused by decode.
- One sub-module: fetch_fifo.
  - Synchronous FIFO of DEPTH entries of {AW+IW} bits.
  - Ports: push, pop, flush, count, head.
  - Flush is synchronous and takes priority over push and pop.

Test Plan:
- Sequential stream: memory word k = 32'hA000_0000+k, inst_ready=1 from reset release -> rd_en addr 0 in cycle 1; inst_valid in cycle 3 with pc 0 / A000_0000; then pc 1, 2, 3 ... one per cycle with no gaps.
- Backpressure: inst_ready=0 for 10 cycles mid-stream -> rd_en stops once count+inflight=4; exactly 4 entries held; on release, pcs continue consecutively with no loss or duplicate.
- Redirect: redirect_valid=1, redirect_pc=9 while pc 3 is at the head and accepted -> pc 3 consumed; next cycle inst_valid=0; next valid instruction is pc 9 / A000_0009; no stale pc 4..6 ever appears.
- Wrap: stream continuously -> pc sequence 14, 15, 0, 1 with matching data.
- Halt: halt=1 with 3 entries queued and 1 in flight -> rd_en=0 from that cycle; 4 instructions drain; inst_valid then low and fetch_busy=0; halt=0 -> next fetch is the following pc.
- Reset mid-operation: sys_rst=0 for one cycle with a full queue -> next cycle inst_valid=0, fetch_busy=0; after release, the first fetch is addr 0 and the first output is pc 0 in cycle 3.
